// File: rtl/trap_ctrl_pkg.sv
// Shared cause codes, interrupt flag position and FSM state encoding for the
// machine-mode trap controller.
package trap_ctrl_pkg;

    localparam logic [31:0] EXC_ILLEGAL = 32'd2;
    localparam logic [31:0] EXC_BREAK   = 32'd3;
    localparam logic [31:0] EXC_LD_MIS  = 32'd4;
    localparam logic [31:0] EXC_ST_MIS  = 32'd6;
    localparam logic [31:0] EXC_ECALL_M = 32'd11;
    localparam logic [31:0] INT_MTI     = 32'd7;
    localparam logic [31:0] INT_MEI     = 32'd11;

    localparam int          INT_BIT     = 31;
    localparam logic [31:0] INT_FLAG    = 32'h1 << INT_BIT;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Combinational trap priority encoder: picks the winning exception or enabled
// interrupt for the committing instruction and produces its cause and mtval.
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   illegal_access_i,
    input  logic [INSTR_WIDTH-1:0] illegal_instr_i,
    input  logic                   ecall_i,
    input  logic                   ebreak_i,
    input  logic                   ld_misalign_i,
    input  logic                   st_misalign_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic                   meip_i,
    input  logic                   mtip_i,
    input  logic                   meie_i,
    input  logic                   mtie_i,
    input  logic                   mstatus_mie_i,
    output logic                   trap_req_o,
    output logic                   is_int_o,
    output logic [DATA_WIDTH-1:0]  cause_o,
    output logic [DATA_WIDTH-1:0]  tval_o
);

    logic mei_req;
    logic mti_req;

    assign mei_req = mstatus_mie_i & meip_i & meie_i;
    assign mti_req = mstatus_mie_i & mtip_i & mtie_i;

    // Exceptions always outrank interrupts; within each group the order below is the priority.
    always_comb begin
        trap_req_o = 1'b1;
        is_int_o   = 1'b0;
        cause_o    = '0;
        tval_o     = '0;
        if (illegal_access_i) begin
            cause_o = DATA_WIDTH'(EXC_ILLEGAL);
            tval_o  = DATA_WIDTH'(illegal_instr_i);
        end else if (ebreak_i) begin
            cause_o = DATA_WIDTH'(EXC_BREAK);
        end else if (ecall_i) begin
            cause_o = DATA_WIDTH'(EXC_ECALL_M);
        end else if (ld_misalign_i) begin
            cause_o = DATA_WIDTH'(EXC_LD_MIS);
            tval_o  = DATA_WIDTH'(mem_addr_i);
        end else if (st_misalign_i) begin
            cause_o = DATA_WIDTH'(EXC_ST_MIS);
            tval_o  = DATA_WIDTH'(mem_addr_i);
        end else if (mei_req) begin
            is_int_o = 1'b1;
            cause_o  = DATA_WIDTH'(INT_FLAG | INT_MEI);
        end else if (mti_req) begin
            is_int_o = 1'b1;
            cause_o  = DATA_WIDTH'(INT_FLAG | INT_MTI);
        end else begin
            trap_req_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller at commit: takes traps and MRET, owns
// mepc/mcause/mtval, and flushes/redirects fetch once the bus has drained.
//
// state       | meaning
// ST_IDLE     | accepting traps and MRET from the committing instruction
// ST_DRAIN    | trap/MRET taken, waiting for outstanding bus transaction
// ST_REDIRECT | flush_pipe asserted with redirect_pc for one cycle
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   cpu_clk_i,
    input  logic                   cpu_rst_i,
    input  logic                   instr_valid_i,
    input  logic [ADDR_WIDTH-1:0]  pc_commit_i,
    input  logic                   illegal_access_i,
    input  logic [INSTR_WIDTH-1:0] illegal_instr_i,
    input  logic                   ecall_i,
    input  logic                   ebreak_i,
    input  logic                   mret_dec_i,
    input  logic                   ld_misalign_i,
    input  logic                   st_misalign_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic                   mem_busy_i,
    input  logic                   meip_i,
    input  logic                   mtip_i,
    input  logic                   meie_i,
    input  logic                   mtie_i,
    input  logic                   mstatus_mie_i,
    input  logic [1:0]             mtvec_mode_i,
    input  logic [31:0]            mtvec_base_i,
    input  logic                   mepc_sel_i,
    input  logic                   mcause_sel_i,
    input  logic                   mtval_sel_i,
    input  logic                   valid_mcsr_wr_i,
    input  logic                   mcsr_set_i,
    input  logic                   mcsr_clr_i,
    input  logic [DATA_WIDTH-1:0]  write_data_i,
    output logic [ADDR_WIDTH-1:0]  mepc_o,
    output logic [DATA_WIDTH-1:0]  mcause_o,
    output logic [DATA_WIDTH-1:0]  mtval_o,
    output logic                   valid_interrupt_o,
    output logic                   mret_o,
    output logic                   kill_commit_o,
    output logic                   flush_pipe_o,
    output logic [ADDR_WIDTH-1:0]  redirect_pc_o
);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0]  mcause_q, mcause_d;
    logic [DATA_WIDTH-1:0]  mtval_q, mtval_d;
    logic [ADDR_WIDTH-1:0]  redirect_q;
    logic                   flush_q;

    logic                   trap_req;
    logic                   is_int;
    logic [DATA_WIDTH-1:0]  cause;
    logic [DATA_WIDTH-1:0]  tval;
    logic                   idle;
    logic                   trap_acc;
    logic                   mret_acc;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  vec_base;
    logic [ADDR_WIDTH-1:0]  trap_target;
    logic [ADDR_WIDTH-1:0]  mepc_wr;

    trap_prio_enc #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_prio_enc (
        .illegal_access_i (illegal_access_i),
        .illegal_instr_i  (illegal_instr_i),
        .ecall_i          (ecall_i),
        .ebreak_i         (ebreak_i),
        .ld_misalign_i    (ld_misalign_i),
        .st_misalign_i    (st_misalign_i),
        .mem_addr_i       (mem_addr_i),
        .meip_i           (meip_i),
        .mtip_i           (mtip_i),
        .meie_i           (meie_i),
        .mtie_i           (mtie_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .trap_req_o       (trap_req),
        .is_int_o         (is_int),
        .cause_o          (cause),
        .tval_o           (tval)
    );

    function automatic logic [DATA_WIDTH-1:0] csr_upd(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic                  set,
        input logic                  clr
    );
        if (set)      return old_val | wdata;
        else if (clr) return old_val & ~wdata;
        else          return wdata;
    endfunction

    // Any trap, including an interrupt, takes precedence over an MRET in the same slot.
    assign idle     = (state_q == ST_IDLE);
    assign trap_acc = idle & instr_valid_i & trap_req;
    assign mret_acc = idle & instr_valid_i & mret_dec_i & ~trap_req;
    assign accept   = trap_acc | mret_acc;

    assign vec_base    = ADDR_WIDTH'(mtvec_base_i);
    assign trap_target = (is_int && mtvec_mode_i == 2'd1)
                       ? vec_base + ADDR_WIDTH'({cause[3:0], 2'b00})
                       : vec_base;

    assign mepc_wr = ADDR_WIDTH'(csr_upd(DATA_WIDTH'(mepc_q), write_data_i, mcsr_set_i, mcsr_clr_i));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = mem_busy_i ? ST_DRAIN : ST_REDIRECT;
            ST_DRAIN:    if (!mem_busy_i) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        if (trap_acc) begin
            mepc_d   = pc_commit_i;
            mcause_d = cause;
            mtval_d  = tval;
        end else if (!mret_acc && valid_mcsr_wr_i) begin
            if (mepc_sel_i)   mepc_d   = {mepc_wr[ADDR_WIDTH-1:2], 2'b00};
            if (mcause_sel_i) mcause_d = csr_upd(mcause_q, write_data_i, mcsr_set_i, mcsr_clr_i);
            if (mtval_sel_i)  mtval_d  = csr_upd(mtval_q, write_data_i, mcsr_set_i, mcsr_clr_i);
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state_q    <= ST_IDLE;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            redirect_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= (state_d == ST_REDIRECT);
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            if (trap_acc)      redirect_q <= trap_target;
            else if (mret_acc) redirect_q <= mepc_q;
        end
    end

    assign kill_commit_o     = instr_valid_i & (accept | ~idle);
    assign valid_interrupt_o = trap_acc & is_int;
    assign mret_o            = mret_acc;
    assign flush_pipe_o      = flush_q;
    assign redirect_pc_o     = redirect_q;
    assign mepc_o            = mepc_q;
    assign mcause_o          = mcause_q;
    assign mtval_o           = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized plus directed bench for trap_ctrl against a cycle-level
// behavioural model of trap acceptance, draining and redirect.
module tb_trap_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        instr_valid;
    logic [31:0] pc_commit;
    logic        illegal_access;
    logic [31:0] illegal_instr;
    logic        ecall, ebreak, mret_dec, ld_misalign, st_misalign;
    logic [31:0] mem_addr;
    logic        mem_busy;
    logic        meip, mtip, meie, mtie, mstatus_mie;
    logic [1:0]  mtvec_mode;
    logic [31:0] mtvec_base;
    logic        mepc_sel, mcause_sel, mtval_sel, valid_mcsr_wr, mcsr_set, mcsr_clr;
    logic [31:0] write_data;
    logic [31:0] mepc, mcause, mtval, redirect_pc;
    logic        valid_interrupt, mret, kill_commit, flush_pipe;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: a taken trap/MRET stays in flight until a cycle with no bus busy,
    // and the flush appears the cycle after that.
    bit          m_inflight, m_flush;
    logic [31:0] m_mepc, m_mcause, m_mtval, m_redir;

    always #5 cpu_clk = ~cpu_clk;

    trap_ctrl u_dut (
        .cpu_clk_i         (cpu_clk),
        .cpu_rst_i         (cpu_rst),
        .instr_valid_i     (instr_valid),
        .pc_commit_i       (pc_commit),
        .illegal_access_i  (illegal_access),
        .illegal_instr_i   (illegal_instr),
        .ecall_i           (ecall),
        .ebreak_i          (ebreak),
        .mret_dec_i        (mret_dec),
        .ld_misalign_i     (ld_misalign),
        .st_misalign_i     (st_misalign),
        .mem_addr_i        (mem_addr),
        .mem_busy_i        (mem_busy),
        .meip_i            (meip),
        .mtip_i            (mtip),
        .meie_i            (meie),
        .mtie_i            (mtie),
        .mstatus_mie_i     (mstatus_mie),
        .mtvec_mode_i      (mtvec_mode),
        .mtvec_base_i      (mtvec_base),
        .mepc_sel_i        (mepc_sel),
        .mcause_sel_i      (mcause_sel),
        .mtval_sel_i       (mtval_sel),
        .valid_mcsr_wr_i   (valid_mcsr_wr),
        .mcsr_set_i        (mcsr_set),
        .mcsr_clr_i        (mcsr_clr),
        .write_data_i      (write_data),
        .mepc_o            (mepc),
        .mcause_o          (mcause),
        .mtval_o           (mtval),
        .valid_interrupt_o (valid_interrupt),
        .mret_o            (mret),
        .kill_commit_o     (kill_commit),
        .flush_pipe_o      (flush_pipe),
        .redirect_pc_o     (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic void ref_trap(output bit req, output bit is_int,
                                     output logic [31:0] cause, output logic [31:0] tval);
        req = 1; is_int = 0; tval = 0;
        if (illegal_access)   begin cause = 2;  tval = illegal_instr; end
        else if (ebreak)      cause = 3;
        else if (ecall)       cause = 11;
        else if (ld_misalign) begin cause = 4;  tval = mem_addr; end
        else if (st_misalign) begin cause = 6;  tval = mem_addr; end
        else if (mstatus_mie && meip && meie) begin is_int = 1; cause = 32'h8000_000B; end
        else if (mstatus_mie && mtip && mtie) begin is_int = 1; cause = 32'h8000_0007; end
        else begin req = 0; cause = 0; end
    endfunction

    function automatic logic [31:0] ref_csr(input logic [31:0] old_val);
        if (mcsr_set)      return old_val | write_data;
        else if (mcsr_clr) return old_val & ~write_data;
        else               return write_data;
    endfunction

    // Called just after a falling edge with inputs driven; checks, advances model, returns at next falling edge.
    task automatic tick();
        bit req, is_int, idle, acc_t, acc_m, n_inf;
        logic [31:0] cause, tval;
        #1;
        ref_trap(req, is_int, cause, tval);
        idle  = !m_inflight && !m_flush;
        acc_t = idle && instr_valid && req;
        acc_m = idle && instr_valid && mret_dec && !req;
        chk("kill_commit", 32'(kill_commit), 32'(instr_valid && (!idle || acc_t || acc_m)));
        chk("valid_interrupt", 32'(valid_interrupt), 32'(acc_t && is_int));
        chk("mret", 32'(mret), 32'(acc_m));
        chk("flush_pipe", 32'(flush_pipe), 32'(m_flush));
        chk("mepc", mepc, m_mepc);
        chk("mcause", mcause, m_mcause);
        chk("mtval", mtval, m_mtval);
        chk("redirect_pc", redirect_pc, m_redir);
        if (cpu_rst) begin
            m_inflight = 0; m_flush = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_redir = 0;
        end else begin
            n_inf = m_inflight || acc_t || acc_m;
            m_flush = 0;
            if (n_inf && !mem_busy) begin n_inf = 0; m_flush = 1; end
            m_inflight = n_inf;
            if (acc_t) begin
                m_mepc = pc_commit; m_mcause = cause; m_mtval = tval;
                m_redir = (is_int && mtvec_mode == 2'd1) ? mtvec_base + 4 * (cause % 16) : mtvec_base;
            end else if (acc_m) begin
                m_redir = m_mepc;
            end else if (valid_mcsr_wr) begin
                if (mepc_sel)   m_mepc   = ref_csr(m_mepc) & 32'hFFFF_FFFC;
                if (mcause_sel) m_mcause = ref_csr(m_mcause);
                if (mtval_sel)  m_mtval  = ref_csr(m_mtval);
            end
        end
        @(negedge cpu_clk);
    endtask

    task automatic quiet_inputs();
        cpu_rst = 0; instr_valid = 0; pc_commit = 0; illegal_access = 0; illegal_instr = 0;
        ecall = 0; ebreak = 0; mret_dec = 0; ld_misalign = 0; st_misalign = 0;
        mem_addr = 0; mem_busy = 0; meip = 0; mtip = 0; meie = 0; mtie = 0; mstatus_mie = 0;
        mtvec_mode = 0; mtvec_base = 0; mepc_sel = 0; mcause_sel = 0; mtval_sel = 0;
        valid_mcsr_wr = 0; mcsr_set = 0; mcsr_clr = 0; write_data = 0;
    endtask

    task automatic settle();
        quiet_inputs();
        repeat (3) tick();
    endtask

    task automatic rand_inputs();
        int op;
        cpu_rst        = ($urandom_range(0, 79) == 0);
        instr_valid    = ($urandom_range(0, 9) < 7);
        pc_commit      = $urandom & 32'hFFFF_FFFC;
        illegal_access = ($urandom_range(0, 11) == 0);
        illegal_instr  = $urandom;
        ecall          = ($urandom_range(0, 11) == 0);
        ebreak         = ($urandom_range(0, 11) == 0);
        mret_dec       = ($urandom_range(0, 7) == 0);
        ld_misalign    = ($urandom_range(0, 11) == 0);
        st_misalign    = ($urandom_range(0, 11) == 0);
        mem_addr       = $urandom;
        mem_busy       = ($urandom_range(0, 9) < 4);
        meip           = ($urandom_range(0, 5) == 0);
        mtip           = ($urandom_range(0, 5) == 0);
        meie           = $urandom_range(0, 1) == 1;
        mtie           = $urandom_range(0, 1) == 1;
        mstatus_mie    = $urandom_range(0, 1) == 1;
        mtvec_mode     = 2'($urandom_range(0, 1));
        mtvec_base     = $urandom & 32'hFFFF_FFFC;
        valid_mcsr_wr  = ($urandom_range(0, 9) < 3);
        mepc_sel       = $urandom_range(0, 2) == 0;
        mcause_sel     = $urandom_range(0, 2) == 0;
        mtval_sel      = $urandom_range(0, 2) == 0;
        op             = $urandom_range(0, 2);
        mcsr_set       = (op == 1);
        mcsr_clr       = (op == 2);
        write_data     = $urandom;
    endtask

    initial begin
        quiet_inputs();
        cpu_rst = 1;
        m_inflight = 0; m_flush = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_redir = 0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        tick();
        settle();

        // illegal instruction, direct vector
        instr_valid = 1; pc_commit = 32'h100; illegal_access = 1; illegal_instr = 32'hFFFF_FFFF;
        mtvec_base = 32'h200;
        tick();
        chk("ill_mepc", mepc, 32'h100);
        chk("ill_mcause", mcause, 32'd2);
        chk("ill_mtval", mtval, 32'hFFFF_FFFF);
        chk("ill_flush", 32'(flush_pipe), 32'd1);
        chk("ill_redirect", redirect_pc, 32'h200);
        settle();

        // MEI and MTI together, vectored
        instr_valid = 1; pc_commit = 32'h80; meip = 1; meie = 1; mtip = 1; mtie = 1;
        mstatus_mie = 1; mtvec_mode = 1; mtvec_base = 32'h400;
        #1 chk("int_vint", 32'(valid_interrupt), 32'd1);
        tick();
        chk("int_mcause", mcause, 32'h8000_000B);
        chk("int_redirect", redirect_pc, 32'h42C);
        settle();

        // interrupts globally disabled
        instr_valid = 1; meip = 1; meie = 1; mtip = 1; mtie = 1; mstatus_mie = 0;
        #1 chk("mie0_kill", 32'(kill_commit), 32'd0);
        tick();
        chk("mie0_flush", 32'(flush_pipe), 32'd0);
        settle();

        // misaligned load while the bus drains for three cycles
        instr_valid = 1; pc_commit = 32'h300; ld_misalign = 1; mem_addr = 32'h1003; mem_busy = 1;
        tick();
        ld_misalign = 0; instr_valid = 0;
        tick();
        tick();
        chk("drain_noflush", 32'(flush_pipe), 32'd0);
        mem_busy = 0;
        tick();
        chk("drain_flush", 32'(flush_pipe), 32'd1);
        chk("drain_mtval", mtval, 32'h1003);
        settle();

        // mepc write then MRET
        valid_mcsr_wr = 1; mepc_sel = 1; write_data = 32'h1236;
        tick();
        chk("wr_mepc", mepc, 32'h1234);
        valid_mcsr_wr = 0; mepc_sel = 0; instr_valid = 1; mret_dec = 1;
        #1 chk("mret_pulse", 32'(mret), 32'd1);
        tick();
        chk("mret_redirect", redirect_pc, 32'h1234);
        settle();

        // MRET suppressed by ECALL
        instr_valid = 1; pc_commit = 32'h40; mret_dec = 1; ecall = 1;
        #1 chk("ecall_nomret", 32'(mret), 32'd0);
        tick();
        chk("ecall_mcause", mcause, 32'd11);
        settle();

        // reset while draining
        instr_valid = 1; pc_commit = 32'h700; ebreak = 1; mem_busy = 1;
        tick();
        ebreak = 0; instr_valid = 0; cpu_rst = 1;
        tick();
        cpu_rst = 0; mem_busy = 0;
        chk("rst_mepc", mepc, 32'd0);
        tick();
        chk("rst_noflush", 32'(flush_pipe), 32'd0);
        settle();

        // trap capture beats a coincident mepc write
        instr_valid = 1; pc_commit = 32'h500; ecall = 1;
        valid_mcsr_wr = 1; mepc_sel = 1; write_data = 32'hAAA0;
        tick();
        chk("wr_vs_trap", mepc, 32'h500);
        settle();

        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap controller at the commit stage of the core. It detects synchronous exceptions and enabled interrupts on the committing instruction, and owns the mepc/mcause/mtval registers. It drives the trap/mret side-band pulses into the machine CSR file and flushes and redirects the fetch pipeline to the trap vector or to mepc. It consumes meie/mtie/mstatus_mie/mtvec from the CSR file and supplies mepc/mcause/mtval read values to it.

Parameters:
ADDR_WIDTH, 32, PC/address width
DATA_WIDTH, 32, CSR data width
INSTR_WIDTH, 32, instruction width

Ports:
cpu_clk  input  1  cpu clock
cpu_rst  input  1  reset; synchronous, active-high
instr_valid  input  1  instruction at commit is valid
pc_commit  input  ADDR_WIDTH  PC of committing instruction
illegal_access  input  1  illegal instruction/CSR access (from CSR decode)
illegal_instr  input  INSTR_WIDTH  offending instruction encoding
ecall  input  1  ECALL at commit
ebreak  input  1  EBREAK at commit
mret_dec  input  1  MRET at commit
ld_misalign  input  1  misaligned load at commit
st_misalign  input  1  misaligned store at commit
mem_addr  input  ADDR_WIDTH  effective address of committing load/store
mem_busy  input  1  outstanding bus transaction not yet acknowledged
meip  input  1  external interrupt pending
mtip  input  1  timer interrupt pending
meie  input  1  external interrupt enable
mtie  input  1  timer interrupt enable
mstatus_mie  input  1  global interrupt enable
mtvec_mode  input  2  0 direct, 1 vectored
mtvec_base  input  32  trap base, bits[1:0] zero
mepc_sel  input  1  CSR address decodes to mepc
mcause_sel  input  1  CSR address decodes to mcause
mtval_sel  input  1  CSR address decodes to mtval
valid_mcsr_wr  input  1  qualified CSR write
mcsr_set  input  1  CSRRS-type write
mcsr_clr  input  1  CSRRC-type write
write_data  input  DATA_WIDTH  CSR write data
mepc  output  ADDR_WIDTH  mepc register
mcause  output  DATA_WIDTH  mcause register
mtval  output  DATA_WIDTH  mtval register
valid_interrupt  output  1  interrupt-taken pulse
mret  output  1  mret-taken pulse
kill_commit  output  1  suppress writeback/side effects of committing instruction
flush_pipe  output  1  flush all younger stages
redirect_pc  output  ADDR_WIDTH  fetch target, valid with flush_pipe

Behaviour:
- Reset (cpu_rst=1 at posedge): state IDLE; mepc, mcause, mtval = 0; all pulse outputs 0; redirect_pc = 0. Reset mid-trap aborts to IDLE with no redirect.
- int_req = mstatus_mie & ((meip & meie) | (mtip & mtie)). exc_any = illegal_access|ebreak|ecall|ld_misalign|st_misalign.
- Priority: exceptions over interrupts. Among exceptions: illegal(2) > ebreak(3) > ecall(11) > ld_misalign(4, mtval=mem_addr) > st_misalign(6, mtval=mem_addr). Illegal: mtval=illegal_instr. Ebreak/ecall: mtval=0. Interrupts: MEI (0x8000_000B) > MTI (0x8000_0007), mtval=0.
- A trap and MRET are accepted only in IDLE with instr_valid=1. An exception suppresses a simultaneous mret_dec.
- Cycle N (accept), combinational outputs:
  - kill_commit=1.
  - valid_interrupt=1 for interrupt traps only.
  - mret=1 for an MRET accept.
- Edge ending N: mepc<=pc_commit (for an interrupt, the PC of the not-yet-executed instruction), plus mcause and mtval. redirect_pc is latched as follows:
  - mtvec_base for exceptions, and for interrupts in direct mode;
  - mtvec_base + 4*cause[3:0] for interrupts in vectored mode;
  - mepc for MRET.
  - Next state is DRAIN if mem_busy, else REDIRECT.
- DRAIN: hold until mem_busy=0, then REDIRECT. kill_commit=1 for any valid instruction.
- REDIRECT: flush_pipe=1 for exactly one cycle with redirect_pc, then IDLE. kill_commit=1 for any valid instruction.
- Latency: flush_pipe one cycle after accept when mem_busy=0.
- New traps and interrupts are ignored outside IDLE; a still-pending interrupt is re-evaluated in IDLE.
- CSR writes:
  - mepc, mcause and mtval are writable when *_sel & valid_mcsr_wr: set → OR, clr → AND-NOT, else replace.
  - mepc bits[1:0] are forced to 0.
  - A trap or MRET capture at the same edge wins over a CSR write.
- Arithmetic: vector offset computed modulo 2^32; no overflow flag.

Decomposition:
- Shared package/header holds cause codes (EXC_ILLEGAL=2, EXC_BREAK=3, EXC_LD_MIS=4, EXC_ST_MIS=6, EXC_ECALL_M=11, INT_MTI=7, INT_MEI=11), the interrupt bit (bit 31) and state encodings (IDLE, DRAIN, REDIRECT).
- One natural sub-module, trap_prio_enc: combinational priority encoder producing cause, mtval and the trap request.

Test Plan:
- Illegal instr 0xFFFF_FFFF at pc 0x100, mtvec_base 0x200 direct → kill_commit in N; mepc=0x100, mcause=2, mtval=0xFFFF_FFFF; flush_pipe at N+1 with redirect_pc=0x200.
- meip=meie=mstatus_mie=1, vectored, base 0x400, pc 0x80 → valid_interrupt pulse; mcause=0x8000_000B; redirect_pc=0x42C.
- Simultaneous meip and mtip with both enabled → mcause=0x8000_000B. With mstatus_mie=0 → no trap, no kill.
- ld_misalign with mem_addr 0x1003 and mem_busy high for 3 cycles → DRAIN 3 cycles, then one flush cycle; mtval=0x1003.
- mret_dec after mepc written to 0x1236 → mepc reads 0x1234; mret pulse; redirect_pc=0x1234. mret_dec together with ecall → ecall trap (mcause=11), no mret pulse.
- cpu_rst asserted in DRAIN → next cycle IDLE, mepc=0, no flush_pipe. CSR write to mepc coincident with trap accept → mepc=trap PC.
